// File: rtl/mmio_axil_master_if.sv
// rtl/mmio_axil_master_if.sv - AXI4-Lite bus bundle with master and slave views
interface mmio_axil_master_if #(
  parameter int ADDR_W = 32
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/mmio_axil_master.sv
// rtl/mmio_axil_master.sv - single-outstanding AXI4-Lite master for MMIO register commands
// Optional per-handshake watchdog enabled by defining MMIO_AXIL_MASTER_TIMEOUT_EN.
module mmio_axil_master #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              user_clk,
  input  logic              axi_lite_aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_wr,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              busy,
`ifdef MMIO_AXIL_MASTER_TIMEOUT_EN
  output logic              timeout_flag,
`endif
  mmio_axil_master_if.master m_axi_lite
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_WR_B = 3'd2,
    ST_RD_A = 3'd3,
    ST_RD_D = 3'd4,
    ST_RSP  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              wr_q, wr_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        resp_q, resp_d;

  logic awvalid, wvalid, bready, arvalid, rready;

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("mmio_axil_master: TIMEOUT_CYC must be at least 2");
  end

`ifdef MMIO_AXIL_MASTER_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        timeout_q, timeout_d;
  logic        watched;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wr_d      = wr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    // Gated by reset so nothing can be accepted while the block is held in reset.
    cmd_ready = (state_q == ST_IDLE) && axi_lite_aresetn;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          wr_d      = cmd_wr;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_wr ? ST_WR : ST_RD_A;
        end
      end
      ST_WR: begin
        // AW and W retire independently; the slave may take them in either order.
        awvalid   = !aw_done_q;
        wvalid    = !w_done_q;
        aw_done_d = aw_done_q || (awvalid && m_axi_lite.awready);
        w_done_d  = w_done_q || (wvalid && m_axi_lite.wready);
        if (aw_done_d && w_done_d) begin
          state_d = ST_WR_B;
        end
      end
      ST_WR_B: begin
        bready = 1'b1;
        if (m_axi_lite.bvalid) begin
          resp_d  = m_axi_lite.bresp;
          rdata_d = 32'd0;
          state_d = ST_RSP;
        end
      end
      ST_RD_A: begin
        arvalid = 1'b1;
        if (m_axi_lite.arready) begin
          state_d = ST_RD_D;
        end
      end
      ST_RD_D: begin
        rready = 1'b1;
        if (m_axi_lite.rvalid) begin
          rdata_d = m_axi_lite.rdata;
          resp_d  = m_axi_lite.rresp;
          state_d = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef MMIO_AXIL_MASTER_TIMEOUT_EN
    timeout_d = timeout_q;
    watched   = (state_q == ST_WR) || (state_q == ST_WR_B) ||
                (state_q == ST_RD_A) || (state_q == ST_RD_D);
    // Abort overrides whatever the state logic chose, including any handshake this cycle.
    if (watched && (tmo_cnt_q == 16'(TIMEOUT_CYC - 1))) begin
      awvalid   = 1'b0;
      wvalid    = 1'b0;
      bready    = 1'b0;
      arvalid   = 1'b0;
      rready    = 1'b0;
      resp_d    = 2'b11;
      rdata_d   = 32'd0;
      state_d   = ST_RSP;
      timeout_d = 1'b1;
    end
    tmo_cnt_d = (watched && (state_d == state_q)) ? tmo_cnt_q + 16'd1 : 16'd0;
`endif
  end

  always_ff @(posedge user_clk or negedge axi_lite_aresetn) begin
    if (!axi_lite_aresetn) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wr_q      <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wr_q      <= wr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

`ifdef MMIO_AXIL_MASTER_TIMEOUT_EN
  always_ff @(posedge user_clk or negedge axi_lite_aresetn) begin
    if (!axi_lite_aresetn) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_flag = timeout_q;
`endif

  assign m_axi_lite.awvalid = awvalid;
  assign m_axi_lite.awaddr  = addr_q;
  assign m_axi_lite.wvalid  = wvalid;
  assign m_axi_lite.wdata   = wdata_q;
  assign m_axi_lite.wstrb   = wstrb_q;
  assign m_axi_lite.bready  = bready;
  assign m_axi_lite.arvalid = arvalid;
  assign m_axi_lite.araddr  = addr_q;
  assign m_axi_lite.rready  = rready;

  assign rsp_valid = (state_q == ST_RSP);
  assign rsp_wr    = wr_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mmio_axil_master.sv
// tb/tb_mmio_axil_master.sv - self-checking bench for mmio_axil_master with a scripted AXI-Lite slave
module tb_mmio_axil_master;
  localparam int ADDR_W = 32;
`ifdef MMIO_AXIL_MASTER_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_wr, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
`ifdef MMIO_AXIL_MASTER_TIMEOUT_EN
  logic        timeout_flag;
`endif

  always #5 clk = ~clk;

  mmio_axil_master_if #(.ADDR_W(ADDR_W)) axi ();

  mmio_axil_master #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
    .user_clk         (clk),
    .axi_lite_aresetn (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_wr           (cmd_wr),
    .cmd_addr         (cmd_addr),
    .cmd_wdata        (cmd_wdata),
    .cmd_wstrb        (cmd_wstrb),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_wr           (rsp_wr),
    .rsp_rdata        (rsp_rdata),
    .rsp_resp         (rsp_resp),
    .busy             (busy),
`ifdef MMIO_AXIL_MASTER_TIMEOUT_EN
    .timeout_flag     (timeout_flag),
`endif
    .m_axi_lite       (axi)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Slave behaviour knobs and observed traffic
  int          aw_wait, w_wait, ar_wait, b_delay, r_delay;
  logic [1:0]  bresp_cfg, rresp_cfg;
  logic [31:0] rdata_cfg;
  logic        hold_chk_en = 1'b1;
  logic [31:0] aw_log[$];
  logic [31:0] ar_log[$];
  logic [35:0] w_log[$];
  int          b_hs_n = 0;
  int          r_hs_n = 0;

  initial begin
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic aw_got, w_got, b_arm, r_arm, b_fire, r_fire, aw_pend, w_pend, ar_pend;
    logic [31:0] aw_prev, ar_prev;
    logic [35:0] w_prev;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
    axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.rvalid = 1'b0; axi.rdata = 32'd0; axi.rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; b_arm = 0; r_arm = 0; b_fire = 0; r_fire = 0;
        aw_pend = 0; w_pend = 0; ar_pend = 0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid = 1'b0; axi.bresp = 2'b00;
        axi.rvalid = 1'b0; axi.rdata = 32'd0; axi.rresp = 2'b00;
      end else begin
        if (b_fire) begin axi.bvalid = 1'b0; axi.bresp = 2'b00; b_fire = 0; end
        if (r_fire) begin axi.rvalid = 1'b0; axi.rdata = 32'd0; axi.rresp = 2'b00; r_fire = 0; end
        if (b_arm) begin
          if (b_cnt == 0) begin axi.bvalid = 1'b1; axi.bresp = bresp_cfg; b_arm = 0; end
          else b_cnt--;
        end
        if (axi.bvalid && axi.bready) begin b_fire = 1; b_hs_n++; end
        if (r_arm) begin
          if (r_cnt == 0) begin axi.rvalid = 1'b1; axi.rdata = rdata_cfg; axi.rresp = rresp_cfg; r_arm = 0; end
          else r_cnt--;
        end
        if (axi.rvalid && axi.rready) begin r_fire = 1; r_hs_n++; end
        if (hold_chk_en) begin
          if (aw_pend) chk("aw_hold", 64'({axi.awvalid, axi.awaddr}), 64'({1'b1, aw_prev}));
          if (w_pend)  chk("w_hold", 64'({axi.wvalid, axi.wdata, axi.wstrb}), 64'({1'b1, w_prev}));
          if (ar_pend) chk("ar_hold", 64'({axi.arvalid, axi.araddr}), 64'({1'b1, ar_prev}));
          if (aw_got)  chk("aw_drop", 64'(axi.awvalid), 64'd0);
          if (w_got)   chk("w_drop", 64'(axi.wvalid), 64'd0);
        end
        axi.awready = axi.awvalid && (aw_cnt >= aw_wait);
        aw_pend = axi.awvalid && !axi.awready;
        aw_prev = axi.awaddr;
        if (axi.awvalid && axi.awready) begin aw_log.push_back(axi.awaddr); aw_got = 1; aw_cnt = 0; end
        else aw_cnt = axi.awvalid ? aw_cnt + 1 : 0;
        axi.wready = axi.wvalid && (w_cnt >= w_wait);
        w_pend = axi.wvalid && !axi.wready;
        w_prev = {axi.wdata, axi.wstrb};
        if (axi.wvalid && axi.wready) begin w_log.push_back({axi.wdata, axi.wstrb}); w_got = 1; w_cnt = 0; end
        else w_cnt = axi.wvalid ? w_cnt + 1 : 0;
        if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_arm = 1; b_cnt = b_delay; end
        axi.arready = axi.arvalid && (ar_cnt >= ar_wait);
        ar_pend = axi.arvalid && !axi.arready;
        ar_prev = axi.araddr;
        if (axi.arvalid && axi.arready) begin ar_log.push_back(axi.araddr); r_arm = 1; r_cnt = r_delay; ar_cnt = 0; end
        else ar_cnt = axi.arvalid ? ar_cnt + 1 : 0;
      end
    end
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_w, w_w, ar_w, b_d, r_d;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    int          hold;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  // Reference: each handshake phase lasts (wait + 1) cycles, plus one cycle to surface rsp_valid.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (v.wr) begin
      r.exp_lat   = ((v.aw_w > v.w_w) ? v.aw_w : v.w_w) + 1 + v.b_d + 1 + 1;
      r.exp_rdata = 32'd0;
      r.exp_resp  = v.bresp;
    end else begin
      r.exp_lat   = v.ar_w + 1 + v.r_d + 1 + 1;
      r.exp_rdata = v.rdata;
      r.exp_resp  = v.rresp;
    end
    return r;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int lat;
    bit ok;
    int b0, r0;
    aw_wait = v.aw_w; w_wait = v.w_w; ar_wait = v.ar_w; b_delay = v.b_d; r_delay = v.r_d;
    bresp_cfg = v.bresp; rresp_cfg = v.rresp; rdata_cfg = v.rdata;
    aw_log.delete(); w_log.delete(); ar_log.delete();
    b0 = b_hs_n; r0 = r_hs_n;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    chk({tag, "_cmd_ready"}, 64'(ok), 64'd1);
    if (!ok) return;
    cmd_valid = 1'b1; cmd_wr = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_accepted"}, 64'({cmd_ready, busy}), 64'(2'b01));
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      cmd_valid = 1'b1; cmd_wr = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
      cmd_wstrb = 4'($urandom); rsp_ready = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
    if (!rsp_valid) begin cmd_valid = 1'b0; rsp_ready = 1'b0; return; end
    for (int h = 0; h <= v.hold; h++) begin
      chk({tag, "_rsp"}, 64'({rsp_valid, rsp_wr, rsp_rdata, rsp_resp, cmd_ready, busy}),
          64'({1'b1, v.wr, v.exp_rdata, v.exp_resp, 1'b0, 1'b1}));
      cmd_valid = (h < v.hold);
      rsp_ready = (h == v.hold);
      @(negedge clk);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    chk({tag, "_done"}, 64'({rsp_valid, cmd_ready, busy}), 64'(3'b010));
    if (v.wr) begin
      chk({tag, "_aw_count"}, 64'(aw_log.size()), 64'd1);
      chk({tag, "_w_count"}, 64'(w_log.size()), 64'd1);
      chk({tag, "_ar_count"}, 64'(ar_log.size()), 64'd0);
      chk({tag, "_b_hs"}, 64'(b_hs_n - b0), 64'd1);
      if (aw_log.size() == 1) chk({tag, "_awaddr"}, 64'(aw_log[0]), 64'(v.addr));
      if (w_log.size() == 1) chk({tag, "_wdata"}, 64'(w_log[0]), 64'({v.wdata, v.wstrb}));
    end else begin
      chk({tag, "_ar_count"}, 64'(ar_log.size()), 64'd1);
      chk({tag, "_aw_count"}, 64'(aw_log.size()), 64'd0);
      chk({tag, "_r_hs"}, 64'(r_hs_n - r0), 64'd1);
      if (ar_log.size() == 1) chk({tag, "_araddr"}, 64'(ar_log[0]), 64'(v.addr));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vec_t v;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 32'd0; cmd_wdata = 32'd0; cmd_wstrb = 4'd0;
    rsp_ready = 1'b0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_delay = 0; r_delay = 0;
    bresp_cfg = 2'b00; rresp_cfg = 2'b00; rdata_cfg = 32'd0;

    //            wr    addr          wdata         strb  aw w ar b r  bresp  rresp  rdata         hold lat exp_rdata     exp_resp
    vecs[0] = '{1'b1, 32'h0000_0004, 32'h1234_5680, 4'hF, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0,         0, 3, 32'h0,         2'b00};
    vecs[1] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 0, 0, 2, 0, 0, 2'b00, 2'b00, 32'hFFFF_FFE0, 0, 5, 32'hFFFF_FFE0, 2'b00};
    vecs[2] = '{1'b1, 32'h0000_0008, 32'hA5A5_0001, 4'h3, 0, 2, 0, 0, 0, 2'b00, 2'b00, 32'h0,         0, 5, 32'h0,         2'b00};
    vecs[3] = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hCAFE_F00D, 5, 3, 32'hCAFE_F00D, 2'b00};
    vecs[4] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'h9, 2, 0, 0, 2, 0, 2'b10, 2'b00, 32'h0,         1, 7, 32'h0,         2'b10};
    vecs[5] = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 0, 0, 0, 0, 3, 2'b00, 2'b11, 32'h0000_0001, 0, 6, 32'h0000_0001, 2'b11};
    vecs[6] = '{1'b1, 32'h0000_0018, 32'h0BAD_CAFE, 4'h6, 1, 1, 0, 0, 0, 2'b01, 2'b00, 32'h0,         2, 4, 32'h0,         2'b01};

    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({cmd_ready, rsp_valid, busy, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 64'd0);
    chk("reset_rsp", 64'({rsp_rdata, rsp_resp, rsp_wr}), 64'd0);
    chk("reset_addr", 64'({axi.awaddr, axi.wstrb}), 64'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("release_cmd_ready", 64'({cmd_ready, busy}), 64'(2'b10));

    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset while a read address is outstanding
    ar_wait = 1000; r_delay = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h30;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst_pre_arvalid", 64'({axi.arvalid, busy}), 64'(2'b11));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", 64'({axi.arvalid, rsp_valid, busy, cmd_ready}), 64'd0);
    repeat (2) @(negedge clk);
    chk("rst_held", 64'({axi.arvalid, rsp_valid, busy, cmd_ready, rsp_rdata}), 64'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release", 64'({cmd_ready, busy, rsp_valid, axi.arvalid}), 64'(4'b1000));
    v = '{1'b0, 32'h44, 32'h0, 4'h0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 32'h5A5A_1234, 0, 0, 32'h0, 2'b00};
    run_txn(model(v), "post_rst");

    for (int i = 0; i < 30; i++) begin
      v.wr = 1'($urandom);
      v.addr = {$urandom_range(0, 255), 2'b00};
      v.wdata = $urandom;
      v.wstrb = 4'($urandom);
      v.aw_w = $urandom_range(0, 3); v.w_w = $urandom_range(0, 3); v.ar_w = $urandom_range(0, 3);
      v.b_d = $urandom_range(0, 3); v.r_d = $urandom_range(0, 3);
      v.bresp = 2'($urandom); v.rresp = 2'($urandom); v.rdata = $urandom;
      v.hold = $urandom_range(0, 3);
      run_txn(model(v), "rand");
    end

`ifdef MMIO_AXIL_MASTER_TIMEOUT_EN
    hold_chk_en = 1'b0;
    ar_wait = 1000;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h50;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("tmo_arvalid_high", 64'(axi.arvalid), 64'd1);
    end
    @(negedge clk);
    chk("tmo_arvalid_drop", 64'({axi.arvalid, rsp_valid}), 64'd0);
    @(negedge clk);
    chk("tmo_rsp", 64'({rsp_valid, rsp_resp, rsp_rdata, timeout_flag}), 64'({1'b1, 2'b11, 32'd0, 1'b1}));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    hold_chk_en = 1'b1;
    chk("tmo_done", 64'({rsp_valid, cmd_ready}), 64'(2'b01));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_axil_master.md
Name: mmio_axil_master

Overview:
- AXI4-Lite master that turns single-beat register commands into AXI-Lite write or read transactions.
- Used by the on-board config sequencer and the debug bridge to program and read back DMA BD base, high and size MMIO registers.
- Supports one outstanding transaction; the response returns on a valid/ready channel.
- Drives AWVALID and WVALID together, because the MMIO slave accepts a write only when both are valid.

Parameters:
- ADDR_W, 32, AXI address width.
- TIMEOUT_CYC, 1024, cycles to wait for any single AXI handshake before aborting (only with the optional feature).

Ports:
- user_clk  in  1  clock.
- axi_lite_aresetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted; high only in IDLE.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_wr  out  1  echoes cmd_wr.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP, or 2'b11 on timeout.
- busy  out  1  high whenever not IDLE.
- m_axi_lite_awvalid/awaddr/awready, m_axi_lite_wvalid/wdata/wstrb/wready, m_axi_lite_bvalid/bresp/bready, m_axi_lite_arvalid/araddr/arready, m_axi_lite_rvalid/rdata/rresp/rready: standard AXI-Lite master directions; addr ADDR_W, data 32, strb 4, resp 2.

Behaviour:
- Reset (async assert, sync release): all valids, bready, rready, rsp_valid and busy = 0; cmd_ready = 0 during reset, 1 in the first cycle after release; all data/addr/resp regs = 0; state = IDLE.
- Command capture: in IDLE, cmd_valid & cmd_ready latches cmd_addr, cmd_wdata, cmd_wstrb and cmd_wr into registers. AXI outputs come only from these registers.
- IDLE -> WR when cmd_wr = 1, else IDLE -> RD_A.
- WR: awvalid and wvalid both assert in the cycle after capture.
  - Each deasserts independently on its own handshake.
  - Both handshakes done -> WR_B.
  - Same-cycle AW and W handshake is legal and goes straight to WR_B.
- WR_B: bready = 1. On bvalid, latch bresp, set rsp_rdata = 0, -> RSP.
- RD_A: arvalid = 1 until arready -> RD_D.
- RD_D: rready = 1. On rvalid, latch rdata and rresp -> RSP.
- RSP: rsp_valid = 1, held stable until rsp_ready, then -> IDLE.
  - cmd_ready rises the cycle after the rsp handshake (no same-cycle back-to-back).
- Valid/address/data stability: every AXI valid, with its address/data, is held until its handshake. A valid never drops without a handshake, except on the optional-feature timeout.
- Minimum latency, zero-wait slave: write cmd accept -> rsp_valid in 3 cycles; read in 3 cycles.
- Early bvalid/rvalid (before this master asserts bready/rready) is held by the slave per protocol and is accepted on entry to WR_B/RD_D.
- Reset mid-transaction: all outputs return to reset values immediately and the transaction is abandoned; no response is issued.
- Ignored inputs: rsp_ready outside RSP and cmd_valid outside IDLE.

Optional Feature:
- Macro: MMIO_AXIL_MASTER_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on every state change and increments in WR, WR_B, RD_A and RD_D.
  - Reaching TIMEOUT_CYC-1 forces all AXI valids and readies to 0, rsp_resp = 2'b11, rsp_rdata = 0, and goes to RSP.
  - Sets a sticky internal timeout flag, which is cleared only by reset.
- Undefined: no counter; the master waits indefinitely.

Test Plan:
- Write 0x12345680 to addr 0x04, strb 4'hF; slave accepts AW and W together and returns bresp 0 -> AW/W fields correct, rsp_valid with rsp_wr = 1, rsp_resp = 0, rsp_rdata = 0, 3 cycles after accept.
- Read addr 0x20 with slave rdata = 0xFFFFFFE0 and 2 wait cycles on arready -> arvalid/araddr held stable 3 cycles, rsp_rdata = 0xFFFFFFE0, rsp_resp = 0.
- Write where wready comes 2 cycles after awready -> awvalid drops after its handshake, wvalid held until wready, exactly one bready handshake.
- rsp_ready held low 5 cycles -> rsp_valid and rsp fields stable, cmd_ready = 0 throughout; after acceptance, a second command is accepted.
- Assert axi_lite_aresetn = 0 while arvalid is high -> arvalid, rsp_valid and busy = 0 asynchronously; after release, a new read completes normally.
- With MMIO_AXIL_MASTER_TIMEOUT_EN, TIMEOUT_CYC = 8, slave never asserts arready -> arvalid drops at cycle 8 and rsp_resp = 2'b11.
